// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter: shares one external single-cycle asynchronous SRAM between the
// CPU data port and the video scanline burst fetcher. Video has priority, but
// after VID_RUN consecutive video slots with the CPU waiting, the CPU gets a slot.
//
// Ports
//   clk_core, reset          core clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU access request, held until cpu_ack
//   cpu_ack, cpu_rdata       one-cycle completion pulse, read data
//   vid_start/addr/len       burst start pulse, start address, length (0 = 256)
//   vid_busy                 burst in progress
//   vid_valid, vid_data      one pulse per fetched burst word, with its data
//   sram_a, sram_wr          registered SRAM address and write strobe
//   host_to_sram             registered SRAM write data
//   sram_to_host             SRAM read data, sampled at the end of each access
module sram_arbiter #(
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned VID_RUN = 4
) (
   input  logic              clk_core,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_start,
   input  logic [ADDR_W-1:0] vid_addr,
   input  logic [7:0]        vid_len,
   output logic              vid_busy,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_data,
   output logic [ADDR_W-1:0] sram_a,
   output logic              sram_wr,
   output logic [DATA_W-1:0] host_to_sram,
   input  logic [DATA_W-1:0] sram_to_host
);

   localparam int unsigned RUN_W = $clog2(VID_RUN + 1);
   localparam int unsigned LEN_W = 9;

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

   owner_t owner, owner_nxt;

   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [LEN_W-1:0]  remain, remain_nxt;
   logic [RUN_W-1:0]  run_cnt, run_nxt;
   logic              inflight, inflight_nxt;

   logic              start_ok;
   logic [LEN_W-1:0]  len_load;
   logic [ADDR_W-1:0] vid_ptr;
   logic [LEN_W-1:0]  vid_left;
   logic [RUN_W-1:0]  run_eff;
   logic              has_words;
   logic              run_below;

   logic [ADDR_W-1:0] sram_a_nxt;
   logic              sram_wr_nxt;
   logic [DATA_W-1:0] host_nxt;
   logic              cpu_ack_nxt;
   logic [DATA_W-1:0] cpu_rdata_nxt;
   logic              busy_nxt;
   logic              vid_valid_nxt;
   logic [DATA_W-1:0] vid_data_nxt;

   // Burst view as seen by this cycle's grant: an accepted start counts immediately.
   always_comb begin
      start_ok  = vid_start && !vid_busy;
      len_load  = (vid_len == 8'd0) ? LEN_W'(256) : {1'b0, vid_len};
      vid_ptr   = start_ok ? vid_addr : ptr;
      vid_left  = start_ok ? len_load : remain;
      run_eff   = start_ok ? '0 : run_cnt;
      has_words = (vid_left != '0);
      run_below = (run_eff < RUN_W'(VID_RUN));
   end

   // Owner (state) register: who occupies the next access cycle.
   always_ff @(posedge clk_core) begin
      if (reset) owner <= OWN_IDLE;
      else       owner <= owner_nxt;
   end

   // Grant: video unless the waiting CPU has sat through VID_RUN video slots.
   // inflight blocks a second CPU grant while the held cpu_req is still
   // the one being served (access cycle and ack cycle).
   always_comb begin
      owner_nxt = OWN_IDLE;
      if (has_words && (!cpu_req || inflight || run_below))
         owner_nxt = OWN_VID;
      else if (cpu_req && !inflight)
         owner_nxt = OWN_CPU;
   end

   // Next values of all registered outputs and burst bookkeeping.
   always_comb begin
      sram_a_nxt    = sram_a;
      sram_wr_nxt   = 1'b0;
      host_nxt      = host_to_sram;
      ptr_nxt       = vid_ptr;
      remain_nxt    = vid_left;
      inflight_nxt  = inflight;
      run_nxt       = run_eff;

      case (owner_nxt)
         OWN_VID: begin
            sram_a_nxt = vid_ptr;
            ptr_nxt    = vid_ptr + ADDR_W'(1);
            remain_nxt = vid_left - LEN_W'(1);
         end
         OWN_CPU: begin
            sram_a_nxt  = cpu_addr;
            sram_wr_nxt = cpu_we;
            if (cpu_we) host_nxt = cpu_wdata;
         end
         default: ;
      endcase

      // Run length only accumulates while the CPU is actually waiting.
      if (owner_nxt == OWN_CPU || !cpu_req)
         run_nxt = '0;
      else if (owner_nxt == OWN_VID && run_below)
         run_nxt = run_eff + RUN_W'(1);

      if (owner_nxt == OWN_CPU) inflight_nxt = 1'b1;
      else if (cpu_ack)         inflight_nxt = 1'b0;

      // Results of the access cycle currently on the bus.
      cpu_ack_nxt   = (owner == OWN_CPU);
      cpu_rdata_nxt = (owner == OWN_CPU && !sram_wr) ? sram_to_host : cpu_rdata;
      vid_valid_nxt = (owner == OWN_VID);
      vid_data_nxt  = (owner == OWN_VID) ? sram_to_host : vid_data;

      // Busy drops after the last word's valid, once no video access remains.
      busy_nxt = vid_busy;
      if (start_ok)
         busy_nxt = 1'b1;
      else if (vid_busy && remain == '0 && vid_valid && owner != OWN_VID)
         busy_nxt = 1'b0;
   end

   // Output and bookkeeping registers.
   always_ff @(posedge clk_core) begin
      if (reset) begin
         sram_a       <= '0;
         sram_wr      <= 1'b0;
         host_to_sram <= '0;
         cpu_ack      <= 1'b0;
         cpu_rdata    <= '0;
         vid_busy     <= 1'b0;
         vid_valid    <= 1'b0;
         vid_data     <= '0;
         ptr          <= '0;
         remain       <= '0;
         run_cnt      <= '0;
         inflight     <= 1'b0;
      end else begin
         sram_a       <= sram_a_nxt;
         sram_wr      <= sram_wr_nxt;
         host_to_sram <= host_nxt;
         cpu_ack      <= cpu_ack_nxt;
         cpu_rdata    <= cpu_rdata_nxt;
         vid_busy     <= busy_nxt;
         vid_valid    <= vid_valid_nxt;
         vid_data     <= vid_data_nxt;
         ptr          <= ptr_nxt;
         remain       <= remain_nxt;
         run_cnt      <= run_nxt;
         inflight     <= inflight_nxt;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// tb_sram_arbiter: directed bench for sram_arbiter. A behavioural SRAM answers
// reads with 0xC000|addr unless the word was written. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_sram_arbiter;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DATA_W = 16;

   logic              clk_core = 1'b0;
   logic              reset;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              vid_start;
   logic [ADDR_W-1:0] vid_addr;
   logic [7:0]        vid_len;
   logic              vid_busy;
   logic              vid_valid;
   logic [DATA_W-1:0] vid_data;
   logic [ADDR_W-1:0] sram_a;
   logic              sram_wr;
   logic [DATA_W-1:0] host_to_sram;
   logic [DATA_W-1:0] sram_to_host;

   always #5 clk_core = ~clk_core;

   sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .VID_RUN(4)) dut (
      .clk_core    (clk_core),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .vid_start   (vid_start),
      .vid_addr    (vid_addr),
      .vid_len     (vid_len),
      .vid_busy    (vid_busy),
      .vid_valid   (vid_valid),
      .vid_data    (vid_data),
      .sram_a      (sram_a),
      .sram_wr     (sram_wr),
      .host_to_sram(host_to_sram),
      .sram_to_host(sram_to_host)
   );

   // SRAM model: unwritten words read back as 0xC000 | address.
   bit [DATA_W-1:0] wmem [1 << ADDR_W];
   bit              wv   [1 << ADDR_W];
   assign sram_to_host = wv[sram_a] ? wmem[sram_a] : (16'hC000 | 16'(sram_a));
   always @(posedge clk_core) begin
      if (sram_wr === 1'b1) begin
         wmem[sram_a] <= host_to_sram;
         wv[sram_a]   <= 1'b1;
      end
   end

   int errors = 0;
   int checks = 0;

   // Per-sequence observation state, recorded at each falling edge.
   int                rel, vcnt, wr_cnt, ack_cnt, ack_at, last_valid;
   logic [ADDR_W-1:0] exp_ptr;
   logic [DATA_W-1:0] rd_seen;
   logic [ADDR_W-1:0] sa [512];
   logic              wr [512];
   logic              bz [512];

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rdata;
   } cpu_vec_t;

   cpu_vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic begin_seq();
      rel = 0; vcnt = 0; wr_cnt = 0; ack_cnt = 0; ack_at = -1; last_valid = -1;
   endtask

   // One clock: sample, check burst data order, then play the simple
   // CPU (drop req in the ack cycle) and one-cycle vid_start.
   task automatic tick();
      @(negedge clk_core);
      rel++;
      if (rel < 512) begin
         sa[rel] = sram_a;
         wr[rel] = sram_wr;
         bz[rel] = vid_busy;
      end
      vid_start = 1'b0;
      if (vid_valid === 1'b1) begin
         chk("vid_data", 32'(vid_data), 32'(16'hC000 | 16'(exp_ptr)));
         exp_ptr    = exp_ptr + 14'd1;
         vcnt++;
         last_valid = rel;
      end
      if (sram_wr === 1'b1) wr_cnt++;
      if (cpu_ack === 1'b1) begin
         ack_cnt++;
         if (ack_at < 0) begin
            ack_at  = rel;
            rd_seen = cpu_rdata;
         end
         cpu_req = 1'b0;
      end
   endtask

   task automatic cpu_xfer(input int idx, input cpu_vec_t v);
      begin_seq();
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      repeat (6) tick();
      chk($sformatf("vec%0d_ack_latency", idx), 32'(ack_at), 32'd2);
      chk($sformatf("vec%0d_ack_count", idx), 32'(ack_cnt), 32'd1);
      chk($sformatf("vec%0d_addr", idx), 32'(sa[1]), 32'(v.addr));
      chk($sformatf("vec%0d_wr_pulses", idx), 32'(wr_cnt), 32'(v.we));
      chk($sformatf("vec%0d_wr_cycle", idx), 32'(wr[1]), 32'(v.we));
      chk($sformatf("vec%0d_rdata", idx), 32'(rd_seen), 32'(v.exp_rdata));
   endtask

   task automatic start_burst(input logic [ADDR_W-1:0] a, input logic [7:0] len);
      exp_ptr   = a;
      vid_start = 1'b1;
      vid_addr  = a;
      vid_len   = len;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vid_start = 1'b0; vid_addr = '0; vid_len = '0; exp_ptr = '0;
      begin_seq();

      vecs[0] = '{1'b1, 14'h0123, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b0, 14'h0123, 16'h0000, 16'hBEEF};
      vecs[2] = '{1'b0, 14'h0005, 16'h0000, 16'hC005};
      vecs[3] = '{1'b1, 14'h2000, 16'h1234, 16'hC005};
      vecs[4] = '{1'b0, 14'h2000, 16'h0000, 16'h1234};
      vecs[5] = '{1'b1, 14'h1FFF, 16'hA5A5, 16'h1234};
      vecs[6] = '{1'b0, 14'h1FFF, 16'h0000, 16'hA5A5};
      vecs[7] = '{1'b0, 14'h3FFF, 16'h0000, 16'hFFFF};

      // Reset state.
      tick(); tick();
      reset = 1'b0;
      chk("rst_sram_a", 32'(sram_a), 0);
      chk("rst_sram_wr", 32'(sram_wr), 0);
      chk("rst_host_to_sram", 32'(host_to_sram), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_vid_busy", 32'(vid_busy), 0);
      chk("rst_vid_valid", 32'(vid_valid), 0);
      chk("rst_vid_data", 32'(vid_data), 0);
      tick();

      // CPU accesses on an idle SRAM.
      for (int i = 0; i < 8; i++) cpu_xfer(i, vecs[i]);

      // Uncontended 4-word burst.
      begin_seq();
      start_burst(14'h0010, 8'd4);
      repeat (8) tick();
      for (int j = 0; j < 4; j++)
         chk($sformatf("burst_addr%0d", j), 32'(sa[j+1]), 32'(14'h0010 + j));
      chk("burst_count", 32'(vcnt), 4);
      chk("burst_last_valid", 32'(last_valid), 5);
      chk("burst_busy_final", 32'(bz[5]), 1);
      chk("burst_busy_drop", 32'(bz[6]), 0);
      chk("burst_no_write", 32'(wr_cnt), 0);

      // Address wrap at the top of SRAM.
      begin_seq();
      start_burst(14'h3FFE, 8'd4);
      repeat (8) tick();
      chk("wrap_addr_hi", 32'(sa[2]), 32'h3FFF);
      chk("wrap_addr_0", 32'(sa[3]), 32'h0000);
      chk("wrap_addr_1", 32'(sa[4]), 32'h0001);
      chk("wrap_count", 32'(vcnt), 4);

      // Length 0 means 256 words.
      begin_seq();
      start_burst(14'h0200, 8'd0);
      repeat (262) tick();
      chk("len0_count", 32'(vcnt), 256);
      chk("len0_last_valid", 32'(last_valid), 257);
      chk("len0_last_addr", 32'(sa[256]), 32'h02FF);
      chk("len0_busy_drop", 32'(bz[258]), 0);

      // Contention: 16-word burst with a CPU read requested in the same cycle.
      begin_seq();
      start_burst(14'h0400, 8'd16);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0800;
      repeat (24) tick();
      chk("cont_vid_first", 32'(sa[1]), 32'h0400);
      chk("cont_vid_fourth", 32'(sa[4]), 32'h0403);
      chk("cont_cpu_slot", 32'(sa[5]), 32'h0800);
      chk("cont_vid_resume", 32'(sa[6]), 32'h0404);
      chk("cont_vid_last", 32'(sa[17]), 32'h040F);
      chk("cont_ack_at", 32'(ack_at), 6);
      chk("cont_ack_count", 32'(ack_cnt), 1);
      chk("cont_rdata", 32'(rd_seen), 32'hC800);
      chk("cont_vid_count", 32'(vcnt), 16);
      chk("cont_last_valid", 32'(last_valid), 18);

      // vid_start while busy is ignored.
      begin_seq();
      start_burst(14'h0500, 8'd8);
      tick(); tick(); tick();
      vid_start = 1'b1; vid_addr = 14'h0900; vid_len = 8'd2;
      repeat (10) tick();
      chk("restart_count", 32'(vcnt), 8);
      chk("restart_last_addr", 32'(sa[8]), 32'h0507);
      chk("restart_busy_drop", 32'(bz[10]), 0);

      // vid_start in the final-valid cycle is ignored.
      begin_seq();
      start_burst(14'h0A00, 8'd2);
      tick(); tick(); tick();
      vid_start = 1'b1; vid_addr = 14'h0B00; vid_len = 8'd1;
      repeat (4) tick();
      chk("final_start_count", 32'(vcnt), 2);
      chk("final_start_busy3", 32'(bz[3]), 1);
      chk("final_start_busy4", 32'(bz[4]), 0);
      chk("final_start_busy5", 32'(bz[5]), 0);
      chk("final_start_addr", 32'(sa[5]), 32'h0A01);

      // Reset mid-burst with a CPU write pending.
      begin_seq();
      start_burst(14'h0600, 8'd8);
      tick(); tick(); tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0700; cpu_wdata = 16'h5555;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_sram_a", 32'(sram_a), 0);
      chk("mrst_sram_wr", 32'(sram_wr), 0);
      chk("mrst_host_to_sram", 32'(host_to_sram), 0);
      chk("mrst_cpu_ack", 32'(cpu_ack), 0);
      chk("mrst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("mrst_vid_busy", 32'(vid_busy), 0);
      chk("mrst_vid_valid", 32'(vid_valid), 0);
      chk("mrst_vid_data", 32'(vid_data), 0);
      wr_cnt = 0; ack_cnt = 0;
      repeat (8) tick();
      chk("mrst_vid_count", 32'(vcnt), 4);
      chk("mrst_wr_pulses", 32'(wr_cnt), 1);
      chk("mrst_ack_count", 32'(ack_cnt), 1);
      chk("mrst_wr_cycle", 32'(wr[7]), 1);
      chk("mrst_wr_addr", 32'(sa[7]), 32'h0700);
      chk("mrst_ack_at", 32'(ack_at), 8);
      chk("mrst_busy", 32'(bz[14]), 0);

      // The post-reset write landed.
      cpu_xfer(8, '{1'b0, 14'h0700, 16'h0000, 16'h5555});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
